// File: rtl/alu_decode_pkg.sv
// Shared ALU encodings: function codes, funct7 qualifiers and the opcodes
// that the decode stage recognises.
package ALU_FNS;

  typedef enum logic [2:0] {
    ADD_SUB = 3'd0,
    SLL     = 3'd1,
    SLT     = 3'd2,
    SLTU    = 3'd3,
    XOR     = 3'd4,
    SRL_SRA = 3'd5,
    OR      = 3'd6,
    AND     = 3'd7
  } alu_fn_t;

  typedef enum logic [6:0] {
    ADD_SRL = 7'b0000000,
    SUB_SRA = 7'b0100000
  } funct7_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

endpackage

// File: rtl/alu_decode_regfile.sv
// Architectural register file: two combinational read ports with write-port
// bypass, one synchronous write port, x0 hardwired to zero.
module regfile #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [4:0]       i_wa,
  input  logic [WIDTH-1:0] i_wd,
  input  logic [4:0]       i_ra1,
  input  logic [4:0]       i_ra2,
  output logic [WIDTH-1:0] o_rd1,
  output logic [WIDTH-1:0] o_rd2
);

  logic [WIDTH-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != 5'd0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  // Bypass lets a value written this cycle reach an operand being fetched now.
  always_comb begin
    o_rd1 = r_mem[i_ra1];
    if (i_ra1 == 5'd0)                  o_rd1 = '0;
    else if (i_we && (i_wa == i_ra1))   o_rd1 = i_wd;
  end

  always_comb begin
    o_rd2 = r_mem[i_ra2];
    if (i_ra2 == 5'd0)                  o_rd2 = '0;
    else if (i_we && (i_wa == i_ra2))   o_rd2 = i_wd;
  end

endmodule

// File: rtl/alu_decode.sv
// Decode/operand-fetch stage: turns RV32I OP / OP-IMM instructions into ALU
// inputs held in an output register behind a valid/ready handshake.
module alu_decode
  import ALU_FNS::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output alu_fn_t          fn,
  output funct7_t          funct7,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [4:0]       rd,
  output logic             illegal
);

  logic [6:0]       w_opc;
  logic [6:0]       w_f7;
  alu_fn_t          w_f3;
  logic             w_is_op;
  logic             w_is_imm;
  logic             w_imm_shift;
  logic             w_legal;
  logic             w_accept;
  logic [WIDTH-1:0] w_rs1_val;
  logic [WIDTH-1:0] w_rs2_val;

  alu_fn_t          w_fn_n;
  funct7_t          w_f7_n;
  logic [WIDTH-1:0] w_a_n;
  logic [WIDTH-1:0] w_b_n;
  logic [4:0]       w_rd_n;

  logic             r_valid;
  alu_fn_t          r_fn;
  funct7_t          r_f7;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [4:0]       r_rd;
  logic             r_illegal;

  regfile #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .i_we  (wb_en),
    .i_wa  (wb_rd),
    .i_wd  (wb_data),
    .i_ra1 (instr[19:15]),
    .i_ra2 (instr[24:20]),
    .o_rd1 (w_rs1_val),
    .o_rd2 (w_rs2_val)
  );

  assign w_opc       = instr[6:0];
  assign w_f7        = instr[31:25];
  assign w_f3        = alu_fn_t'(instr[14:12]);
  assign w_is_op     = (w_opc == OPC_OP);
  assign w_is_imm    = (w_opc == OPC_OP_IMM);
  assign w_imm_shift = w_is_imm && ((w_f3 == SLL) || (w_f3 == SRL_SRA));

  assign instr_ready = !r_valid || ex_ready;
  assign w_accept    = instr_valid && instr_ready;

  always_comb begin
    w_legal = 1'b0;
    if (w_is_op) begin
      w_legal = (w_f7 == ADD_SRL) ||
                ((w_f7 == SUB_SRA) && ((w_f3 == ADD_SUB) || (w_f3 == SRL_SRA)));
    end else if (w_is_imm) begin
      case (w_f3)
        SLL:     w_legal = (w_f7 == ADD_SRL);
        SRL_SRA: w_legal = (w_f7 == ADD_SRL) || (w_f7 == SUB_SRA);
        default: w_legal = 1'b1;
      endcase
    end
  end

  // Illegal instructions still flow downstream, but as a harmless zeroed op.
  always_comb begin
    w_fn_n = ADD_SUB;
    w_f7_n = ADD_SRL;
    w_a_n  = '0;
    w_b_n  = '0;
    w_rd_n = 5'd0;
    if (w_legal) begin
      w_fn_n = w_f3;
      w_a_n  = w_rs1_val;
      w_rd_n = instr[11:7];
      if (w_is_op) begin
        w_b_n  = w_rs2_val;
        w_f7_n = funct7_t'(w_f7);
      end else if (w_imm_shift) begin
        w_b_n  = WIDTH'(instr[24:20]);
        w_f7_n = funct7_t'(w_f7);
      end else begin
        w_b_n  = {{(WIDTH-12){instr[31]}}, instr[31:20]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_fn      <= ADD_SUB;
      r_f7      <= ADD_SRL;
      r_a       <= '0;
      r_b       <= '0;
      r_rd      <= 5'd0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_fn      <= w_fn_n;
      r_f7      <= w_f7_n;
      r_a       <= w_a_n;
      r_b       <= w_b_n;
      r_rd      <= w_rd_n;
      r_illegal <= !w_legal;
    end else if (ex_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign ex_valid = r_valid;
  assign fn       = r_fn;
  assign funct7   = r_f7;
  assign a        = r_a;
  assign b        = r_b;
  assign rd       = r_rd;
  assign illegal  = r_illegal;

endmodule
